pipeline_ctrl: RTL and testbench

Central hazard and sequencing controller for the 5-stage MIPS pipeline. It detects load-use hazards and inserts bubbles through the ID/EX register, and it flushes wrong-path instructions on taken branches and jumps. It also produces EX-stage forwarding selects, runs a halt-drain state machine that stops fetch and lets in-flight instructions retire, and keeps performance counters. It sits beside the pipeline registers and drives their enable and clear inputs.

---
 rtl/pipeline_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_pipeline_ctrl.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: hazard and sequencing controller for the 5-stage MIPS pipeline.
//
// It detects load-use hazards and inserts one bubble through ID/EX. It flushes
// wrong-path instructions on taken branches and jumps, and produces the EX-stage
// forwarding selects. A RUN/DRAIN/HALTED machine stops fetch on a halt and lets
// in-flight instructions retire. It also keeps performance counters.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   id_*              ID-stage source registers, read flags, halt decode
//   ex_*              ID/EX sources, destination, regwrite, load flag
//   mem_*, wb_*       EX/MEM and MEM/WB destination and write enables
//   wb_halt           halt instruction has reached WB
//   branch_taken      EX resolved a taken branch or jump
//   go                resume request while halted
//   pc_en, ifid_en    PC / IF/ID load enables (combinational)
//   ifid_flush        IF/ID clear (combinational)
//   bubble_rst        ID/EX clear for a stall (combinational)
//   jump_rst          ID/EX clear for a branch (combinational)
//   fwd_a, fwd_b      EX operand selects: 00 regfile, 01 EX/MEM, 10 MEM/WB
//   halted            registered, controller is halted
//   cycle_cnt         registered, non-halted cycles, wraps
//   stall_cnt         registered, load-use stall cycles, saturates
//   flush_cnt         registered, taken-branch flushes, saturates
module pipeline_ctrl #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_ra,
  input  logic [4:0]       id_rb,
  input  logic             id_uses_ra,
  input  logic             id_uses_rb,
  input  logic             id_halt,
  input  logic [4:0]       ex_ra,
  input  logic [4:0]       ex_rb,
  input  logic [4:0]       ex_desreg,
  input  logic             ex_regwrite,
  input  logic             ex_memtoreg,
  input  logic [4:0]       mem_desreg,
  input  logic             mem_regwrite,
  input  logic [4:0]       wb_desreg,
  input  logic             wb_regwrite,
  input  logic             wb_halt,
  input  logic             branch_taken,
  input  logic             go,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             bubble_rst,
  output logic             jump_rst,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             halted,
  output logic [31:0]      cycle_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {StRun, StDrain, StHalted} state_e;

  state_e           state_q, state_d;
  logic             halted_q, halted_d;
  logic [31:0]      cycle_cnt_q, cycle_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic lu;
  logic stall_evt;

  // A load in EX whose nonzero destination feeds an operand read in ID.
  assign lu = ex_memtoreg && ex_regwrite && (ex_desreg != 5'd0) &&
              ((id_uses_ra && (id_ra == ex_desreg)) || (id_uses_rb && (id_rb == ex_desreg)));

  // A branch in RUN overrides the stall, so only an unbranched hazard counts.
  assign stall_evt = !rst && (state_q == StRun) && !branch_taken && lu;

  // State register
  always_ff @(posedge clk) begin
    state_q  <= state_d;
    halted_q <= halted_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StRun: begin
        // A stalled halt stays in ID, so the move to DRAIN waits for it.
        if (!branch_taken && !lu && id_halt) state_d = StDrain;
      end
      StDrain: begin
        // An older taken branch squashes the halt.
        if (branch_taken)  state_d = StRun;
        else if (wb_halt)  state_d = StHalted;
      end
      StHalted: begin
        if (go) state_d = StRun;
      end
      default: state_d = StRun;
    endcase
    if (rst) state_d = StRun;
    halted_d = (state_d == StHalted);
  end

  // Output logic
  always_comb begin
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    ifid_flush = 1'b0;
    bubble_rst = 1'b0;
    jump_rst   = 1'b0;
    if (rst) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      ifid_flush = 1'b1;
      bubble_rst = 1'b1;
    end else begin
      case (state_q)
        StRun: begin
          if (branch_taken) begin
            ifid_flush = 1'b1;
            jump_rst   = 1'b1;
          end else if (lu) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            bubble_rst = 1'b1;
          end
        end
        StDrain: begin
          // Fetch stops and nops are shifted into ID.
          pc_en      = branch_taken;
          ifid_flush = 1'b1;
          jump_rst   = branch_taken;
        end
        StHalted: begin
          pc_en      = 1'b0;
          ifid_en    = 1'b0;
          bubble_rst = 1'b1;
        end
        default: begin
          pc_en   = 1'b0;
          ifid_en = 1'b0;
        end
      endcase
    end
  end

  // Forwarding selects; EX/MEM is younger, so it wins over MEM/WB.
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (!rst) begin
      if (mem_regwrite && (mem_desreg != 5'd0) && (mem_desreg == ex_ra)) begin
        fwd_a = 2'b01;
      end else if (wb_regwrite && (wb_desreg != 5'd0) && (wb_desreg == ex_ra)) begin
        fwd_a = 2'b10;
      end
      if (mem_regwrite && (mem_desreg != 5'd0) && (mem_desreg == ex_rb)) begin
        fwd_b = 2'b01;
      end else if (wb_regwrite && (wb_desreg != 5'd0) && (wb_desreg == ex_rb)) begin
        fwd_b = 2'b10;
      end
    end
  end

  // Performance counters
  always_comb begin
    cycle_cnt_d = cycle_cnt_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (rst) begin
      cycle_cnt_d = '0;
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (state_q != StHalted) cycle_cnt_d = cycle_cnt_q + 32'd1;
      if (stall_evt && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if (jump_rst && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    cycle_cnt_q <= cycle_cnt_d;
    stall_cnt_q <= stall_cnt_d;
    flush_cnt_q <= flush_cnt_d;
  end

  assign halted    = halted_q;
  assign cycle_cnt = cycle_cnt_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: a constant vector table, hand-written multi-cycle
// sequences and randomized cycles, all scored against a behavioural model.
module tb_pipeline_ctrl;

  localparam int unsigned CNT_W   = 4;
  localparam int          SAT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic [4:0] id_ra, id_rb, ex_ra, ex_rb, ex_desreg, mem_desreg, wb_desreg;
  logic id_uses_ra, id_uses_rb, id_halt, ex_regwrite, ex_memtoreg;
  logic mem_regwrite, wb_regwrite, wb_halt, branch_taken, go;
  logic pc_en, ifid_en, ifid_flush, bubble_rst, jump_rst, halted;
  logic [1:0] fwd_a, fwd_b;
  logic [31:0] cycle_cnt;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  pipeline_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .id_ra(id_ra), .id_rb(id_rb), .id_uses_ra(id_uses_ra), .id_uses_rb(id_uses_rb),
    .id_halt(id_halt),
    .ex_ra(ex_ra), .ex_rb(ex_rb), .ex_desreg(ex_desreg),
    .ex_regwrite(ex_regwrite), .ex_memtoreg(ex_memtoreg),
    .mem_desreg(mem_desreg), .mem_regwrite(mem_regwrite),
    .wb_desreg(wb_desreg), .wb_regwrite(wb_regwrite), .wb_halt(wb_halt),
    .branch_taken(branch_taken), .go(go),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
    .bubble_rst(bubble_rst), .jump_rst(jump_rst),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .halted(halted),
    .cycle_cnt(cycle_cnt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  typedef struct packed {
    logic       rst;
    logic [4:0] id_ra, id_rb;
    logic       uses_ra, uses_rb, id_halt;
    logic [4:0] ex_ra, ex_rb, ex_d;
    logic       ex_rw, ex_mtr;
    logic [4:0] mem_d;
    logic       mem_rw;
    logic [4:0] wb_d;
    logic       wb_rw, wb_halt, br, go;
  } in_t;

  typedef struct packed {
    logic [4:0] id_ra, id_rb;
    logic       uses_ra, uses_rb;
    logic [4:0] ex_ra, ex_rb, ex_d;
    logic       ex_rw, ex_mtr;
    logic [4:0] mem_d;
    logic       mem_rw;
    logic [4:0] wb_d;
    logic       wb_rw, br;
    logic       pc, ifid, flush, bub, jump;
    logic [1:0] fa, fb;
  } vec_t;

  typedef enum int {ModeRun, ModeDrain, ModeHalted} mode_e;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;

  // Model state
  mode_e       m_mode  = ModeRun;
  bit          m_valid = 1'b0;
  logic [31:0] m_cycle = '0;
  int          m_stall = 0;
  int          m_flush = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic bit load_use(input in_t v);
    bit is_load;
    is_load = v.ex_mtr && v.ex_rw && (v.ex_d != 5'd0);
    return is_load && ((v.uses_ra && v.id_ra == v.ex_d) || (v.uses_rb && v.id_rb == v.ex_d));
  endfunction

  // Youngest producer that writes the operand wins; r0 is hardwired zero.
  function automatic logic [1:0] fwd_ref(input logic [4:0] src, input in_t v);
    logic [4:0] dst [2];
    logic       wr  [2];
    dst[0] = v.mem_d; wr[0] = v.mem_rw;
    dst[1] = v.wb_d;  wr[1] = v.wb_rw;
    if (v.rst || src == 5'd0) return 2'b00;
    for (int s = 0; s < 2; s++) begin
      if (wr[s] && dst[s] == src) return 2'(s + 1);
    end
    return 2'b00;
  endfunction

  function automatic int sat_inc(input int c);
    return (c >= SAT_MAX) ? c : c + 1;
  endfunction

  task automatic step(input in_t v);
    logic e_pc, e_ifid, e_flush, e_bub, e_jump;
    bit   lu_m, stall_m;
    @(negedge clk);
    cyc++;
    rst = v.rst; id_ra = v.id_ra; id_rb = v.id_rb;
    id_uses_ra = v.uses_ra; id_uses_rb = v.uses_rb; id_halt = v.id_halt;
    ex_ra = v.ex_ra; ex_rb = v.ex_rb; ex_desreg = v.ex_d;
    ex_regwrite = v.ex_rw; ex_memtoreg = v.ex_mtr;
    mem_desreg = v.mem_d; mem_regwrite = v.mem_rw;
    wb_desreg = v.wb_d; wb_regwrite = v.wb_rw; wb_halt = v.wb_halt;
    branch_taken = v.br; go = v.go;
    #1;
    lu_m    = load_use(v);
    stall_m = 1'b0;
    if (v.rst) begin
      {e_pc, e_ifid, e_flush, e_bub, e_jump} = 5'b00110;
    end else if (m_mode == ModeHalted) begin
      {e_pc, e_ifid, e_flush, e_bub, e_jump} = 5'b00010;
    end else if (m_mode == ModeDrain) begin
      {e_pc, e_ifid, e_flush, e_bub, e_jump} = {v.br, 3'b110, v.br};
    end else if (v.br) begin
      {e_pc, e_ifid, e_flush, e_bub, e_jump} = 5'b11101;
    end else if (lu_m) begin
      {e_pc, e_ifid, e_flush, e_bub, e_jump} = 5'b00010;
      stall_m = 1'b1;
    end else begin
      {e_pc, e_ifid, e_flush, e_bub, e_jump} = 5'b11000;
    end
    check("pc_en", 32'(pc_en), 32'(e_pc));
    check("ifid_en", 32'(ifid_en), 32'(e_ifid));
    // IF/ID clear is unconstrained while halted since IF/ID is frozen.
    if (v.rst || m_mode != ModeHalted) check("ifid_flush", 32'(ifid_flush), 32'(e_flush));
    check("bubble_rst", 32'(bubble_rst), 32'(e_bub));
    check("jump_rst", 32'(jump_rst), 32'(e_jump));
    check("fwd_a", 32'(fwd_a), 32'(fwd_ref(v.ex_ra, v)));
    check("fwd_b", 32'(fwd_b), 32'(fwd_ref(v.ex_rb, v)));
    if (m_valid) begin
      check("halted", 32'(halted), 32'(m_mode == ModeHalted));
      check("cycle_cnt", cycle_cnt, m_cycle);
      check("stall_cnt", 32'(stall_cnt), 32'(m_stall));
      check("flush_cnt", 32'(flush_cnt), 32'(m_flush));
    end
    // Advance the model to the state after this cycle's edge.
    if (v.rst) begin
      m_mode = ModeRun; m_cycle = '0; m_stall = 0; m_flush = 0; m_valid = 1'b1;
    end else begin
      if (m_mode != ModeHalted) m_cycle = m_cycle + 32'd1;
      if (stall_m) m_stall = sat_inc(m_stall);
      if (e_jump)  m_flush = sat_inc(m_flush);
      case (m_mode)
        ModeRun:    if (!v.br && !lu_m && v.id_halt) m_mode = ModeDrain;
        ModeDrain:  if (v.br) m_mode = ModeRun; else if (v.wb_halt) m_mode = ModeHalted;
        default:    if (v.go) m_mode = ModeRun;
      endcase
    end
  endtask

  in_t  idle_v, v;
  vec_t tbl [8];
  logic [31:0] frozen;

  initial begin
    idle_v = '0;
    // id_ra,id_rb,ua,ub, ex_ra,ex_rb,ex_d,rw,mtr, mem_d,mem_rw, wb_d,wb_rw, br,
    // pc,ifid,flush,bub,jump, fwd_a,fwd_b
    tbl[0] = '{5'd2, 5'd0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd2, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0,
               1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00};
    tbl[1] = '{5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0,
               1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00};
    tbl[2] = '{5'd2, 5'd0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd2, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0,
               1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 2'b00};
    tbl[3] = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 5'd7, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 5'd5, 1'b1,
               1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00};
    tbl[4] = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 5'd7, 5'd0, 1'b0, 1'b0, 5'd5, 1'b0, 5'd5, 1'b1,
               1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00};
    tbl[5] = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1,
               1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00};
    tbl[6] = '{5'd9, 5'd9, 1'b0, 1'b1, 5'd4, 5'd3, 5'd9, 1'b1, 1'b1, 5'd4, 1'b1, 5'd3, 1'b1,
               1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 2'b10};
    tbl[7] = '{5'd2, 5'd0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0,
               1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00};

    // Reset with hazards and forwarding matches present; reset must dominate.
    v = '0; v.rst = 1'b1; v.br = 1'b1; v.ex_ra = 5'd5; v.mem_d = 5'd5; v.mem_rw = 1'b1;
    v.ex_rb = 5'd6; v.wb_d = 5'd6; v.wb_rw = 1'b1;
    step(v);
    step(v);
    step(idle_v);
    check("reset_halted", 32'(halted), 32'd0);
    check("reset_cycle_cnt", cycle_cnt, 32'd0);
    check("reset_stall_cnt", 32'(stall_cnt), 32'd0);

    // Constant vector table, all applied in RUN.
    for (int i = 0; i < 8; i++) begin
      v = '0;
      v.id_ra = tbl[i].id_ra; v.id_rb = tbl[i].id_rb;
      v.uses_ra = tbl[i].uses_ra; v.uses_rb = tbl[i].uses_rb;
      v.ex_ra = tbl[i].ex_ra; v.ex_rb = tbl[i].ex_rb; v.ex_d = tbl[i].ex_d;
      v.ex_rw = tbl[i].ex_rw; v.ex_mtr = tbl[i].ex_mtr;
      v.mem_d = tbl[i].mem_d; v.mem_rw = tbl[i].mem_rw;
      v.wb_d = tbl[i].wb_d; v.wb_rw = tbl[i].wb_rw; v.br = tbl[i].br;
      step(v);
      check($sformatf("tbl%0d_pc_en", i), 32'(pc_en), 32'(tbl[i].pc));
      check($sformatf("tbl%0d_ifid_en", i), 32'(ifid_en), 32'(tbl[i].ifid));
      check($sformatf("tbl%0d_ifid_flush", i), 32'(ifid_flush), 32'(tbl[i].flush));
      check($sformatf("tbl%0d_bubble", i), 32'(bubble_rst), 32'(tbl[i].bub));
      check($sformatf("tbl%0d_jump", i), 32'(jump_rst), 32'(tbl[i].jump));
      check($sformatf("tbl%0d_fwd_a", i), 32'(fwd_a), 32'(tbl[i].fa));
      check($sformatf("tbl%0d_fwd_b", i), 32'(fwd_b), 32'(tbl[i].fb));
    end
    step(idle_v);
    check("tbl_stall_cnt", 32'(stall_cnt), 32'd2);
    check("tbl_flush_cnt", 32'(flush_cnt), 32'd1);

    // go outside HALTED has no effect.
    v = '0; v.go = 1'b1;
    step(v);
    step(idle_v);
    check("go_in_run_halted", 32'(halted), 32'd0);

    // Halt drain: halt in ID at t, halted from t+4, resume on go.
    v = '0; v.id_halt = 1'b1;
    step(v);
    check("halt_t_pc_en", 32'(pc_en), 32'd1);
    step(idle_v);
    check("drain_pc_en", 32'(pc_en), 32'd0);
    check("drain_ifid_flush", 32'(ifid_flush), 32'd1);
    check("drain_ifid_en", 32'(ifid_en), 32'd1);
    step(idle_v);
    v = '0; v.wb_halt = 1'b1;
    step(v);
    check("wb_halt_not_yet_halted", 32'(halted), 32'd0);
    step(idle_v);
    check("halted_t4", 32'(halted), 32'd1);
    check("halted_pc_en", 32'(pc_en), 32'd0);
    check("halted_bubble", 32'(bubble_rst), 32'd1);
    frozen = m_cycle;
    step(idle_v);
    step(idle_v);
    step(idle_v);
    check("cycle_cnt_frozen", cycle_cnt, frozen);
    v = '0; v.go = 1'b1;
    step(v);
    check("go_cycle_pc_en", 32'(pc_en), 32'd0);
    step(idle_v);
    check("resume_pc_en", 32'(pc_en), 32'd1);
    check("resume_halted", 32'(halted), 32'd0);

    // Squashed halt: older branch resolves while draining.
    v = '0; v.id_halt = 1'b1;
    step(v);
    v = '0; v.br = 1'b1;
    step(v);
    check("squash_jump_rst", 32'(jump_rst), 32'd1);
    check("squash_pc_en", 32'(pc_en), 32'd1);
    step(idle_v);
    check("squash_run_flush", 32'(ifid_flush), 32'd0);
    check("squash_run_pc_en", 32'(pc_en), 32'd1);
    v = '0; v.wb_halt = 1'b1;
    step(v);
    step(idle_v);
    check("squash_never_halted", 32'(halted), 32'd0);

    // Halt deferred by a load-use stall on the same cycle.
    v = tbl[0] == tbl[0] ? '0 : '0;
    v.id_halt = 1'b1; v.id_ra = 5'd2; v.uses_ra = 1'b1; v.ex_d = 5'd2;
    v.ex_rw = 1'b1; v.ex_mtr = 1'b1;
    step(v);
    v = '0; v.id_halt = 1'b1;
    step(v);
    check("deferred_halt_pc_en", 32'(pc_en), 32'd1);
    step(idle_v);
    check("deferred_drain_pc_en", 32'(pc_en), 32'd0);

    // Reset in DRAIN.
    v = '0; v.rst = 1'b1;
    step(v);
    step(idle_v);
    check("rst_drain_pc_en", 32'(pc_en), 32'd1);
    check("rst_drain_cycle_cnt", cycle_cnt, 32'd0);

    // Reset in HALTED.
    v = '0; v.id_halt = 1'b1;
    step(v);
    step(idle_v);
    step(idle_v);
    v = '0; v.wb_halt = 1'b1;
    step(v);
    step(idle_v);
    check("pre_rst_halted", 32'(halted), 32'd1);
    v = '0; v.rst = 1'b1;
    step(v);
    step(idle_v);
    check("rst_halted_halted", 32'(halted), 32'd0);
    check("rst_halted_pc_en", 32'(pc_en), 32'd1);

    // Saturation: 2^CNT_W+3 stalls and flushes, then reset.
    v = '0; v.id_ra = 5'd2; v.uses_ra = 1'b1; v.ex_d = 5'd2; v.ex_rw = 1'b1; v.ex_mtr = 1'b1;
    for (int i = 0; i < (1 << CNT_W) + 3; i++) step(v);
    step(idle_v);
    check("stall_cnt_sat", 32'(stall_cnt), 32'(SAT_MAX));
    v.br = 1'b1;
    for (int i = 0; i < (1 << CNT_W) + 3; i++) step(v);
    step(idle_v);
    check("flush_cnt_sat", 32'(flush_cnt), 32'(SAT_MAX));
    v = '0; v.rst = 1'b1;
    step(v);
    step(idle_v);
    check("sat_rst_stall_cnt", 32'(stall_cnt), 32'd0);
    check("sat_rst_flush_cnt", 32'(flush_cnt), 32'd0);

    // Randomized cycles scored by the model.
    for (int i = 0; i < 600; i++) begin
      v.rst     = ($urandom_range(0, 59) == 0);
      v.id_ra   = 5'($urandom_range(0, 3));
      v.id_rb   = 5'($urandom_range(0, 3));
      v.uses_ra = 1'($urandom_range(0, 1));
      v.uses_rb = 1'($urandom_range(0, 1));
      v.id_halt = ($urandom_range(0, 9) == 0);
      v.ex_ra   = 5'($urandom_range(0, 3));
      v.ex_rb   = 5'($urandom_range(0, 3));
      v.ex_d    = 5'($urandom_range(0, 3));
      v.ex_rw   = 1'($urandom_range(0, 1));
      v.ex_mtr  = 1'($urandom_range(0, 1));
      v.mem_d   = 5'($urandom_range(0, 3));
      v.mem_rw  = 1'($urandom_range(0, 1));
      v.wb_d    = 5'($urandom_range(0, 3));
      v.wb_rw   = 1'($urandom_range(0, 1));
      v.wb_halt = ($urandom_range(0, 3) == 0);
      v.br      = ($urandom_range(0, 5) == 0);
      v.go      = ($urandom_range(0, 3) == 0);
      step(v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
